alarm_controller: RTL and testbench

//  Sequential, parametrised successor to the combinational 3-input alarm logic.
//  - Monitors N_SENSORS maskable zones; each zone is either instant or delayed.
//  - Delayed zones start an entry countdown; instant zones trip the siren at once.
//  - The siren is time-limited. Tripped zones are latched until the next arm.
//  - Sits between the raw sensor inputs (already synchronised) and the siren/LED drivers.

---
 rtl/alarm_pkg.sv | 19 +
 rtl/alarm_timer.sv | 28 ++
 rtl/alarm_controller.sv | 127 ++++++++++++
 tb/tb_alarm_controller.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding and helpers for the alarm controller.
// Codes 5..7 are unused and recover to DISARMED.
package alarm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_ALARM    = 3'd3,
    ST_HOLD     = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the ENTRY and ALARM phases.
// Decrements saturate at zero so the count never wraps.
module alarm_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alarm_controller.sv
// Multi-zone alarm controller: instant/delayed zones, timed siren,
// sticky per-zone trip record cleared on arming.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int N_SENSORS   = 3,
  parameter int ENTRY_DELAY = 8,
  parameter int SIREN_TIME  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [N_SENSORS-1:0] sensor,
  input  logic [N_SENSORS-1:0] sensor_mask,
  input  logic [N_SENSORS-1:0] delay_zone,
  output logic                 armed,
  output logic                 pending,
  output logic                 siren,
  output logic [N_SENSORS-1:0] alarm_latch,
  output logic [STATE_W-1:0]   state
);

  localparam int CNT_W =
    $clog2(max_int(ENTRY_DELAY, SIREN_TIME) + 1);

  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME - 1);

  state_t                state_q, state_d;
  logic [N_SENSORS-1:0]  latch_q, latch_d;
  logic [N_SENSORS-1:0]  trip, inst, dly;
  logic                  load, dec, zero, in_armed;
  logic [CNT_W-1:0]      load_val;

  assign trip = sensor & sensor_mask;
  assign inst = trip & ~delay_zone;
  assign dly  = trip & delay_zone;

  assign in_armed = (state_q == ST_ARMED) || (state_q == ST_ENTRY) ||
                    (state_q == ST_ALARM) || (state_q == ST_HOLD);

  alarm_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .zero     (zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_DISARMED;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    load     = 1'b0;
    load_val = '0;
    dec      = 1'b0;
    // Trips are recorded in every armed state, even on a disarm edge.
    if (in_armed) begin
      latch_d = latch_q | trip;
    end
    if (disarm) begin
      state_d = ST_DISARMED;
    end else begin
      unique case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            state_d = ST_ARMED;
            latch_d = '0;
          end
        end
        ST_ARMED: begin
          if (|inst) begin
            state_d  = ST_ALARM;
            load     = 1'b1;
            load_val = SIREN_LD;
          end else if (|dly) begin
            state_d  = ST_ENTRY;
            load     = 1'b1;
            load_val = ENTRY_LD;
          end
        end
        ST_ENTRY: begin
          if ((|inst) || zero) begin
            state_d  = ST_ALARM;
            load     = 1'b1;
            load_val = SIREN_LD;
          end else begin
            dec = 1'b1;
          end
        end
        ST_ALARM: begin
          if (zero) begin
            state_d = ST_HOLD;
          end else begin
            dec = 1'b1;
          end
        end
        ST_HOLD: begin
          if (|trip) begin
            state_d  = ST_ALARM;
            load     = 1'b1;
            load_val = SIREN_LD;
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

  assign state       = state_q;
  assign armed       = in_armed;
  assign pending     = (state_q == ST_ENTRY);
  assign siren       = (state_q == ST_ALARM);
  assign alarm_latch = latch_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed scoreboard bench for alarm_controller with
// ENTRY_DELAY=4, SIREN_TIME=6, three zones, zone 1 delayed.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic [2:0] sensor = 3'b000;
  logic [2:0] sensor_mask = 3'b111;
  logic [2:0] delay_zone = 3'b010;
  logic       armed, pending, siren;
  logic [2:0] alarm_latch;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [2:0] lat;
  } exp_t;

  exp_t sb[$];

  alarm_controller #(
    .N_SENSORS   (3),
    .ENTRY_DELAY (4),
    .SIREN_TIME  (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .disarm      (disarm),
    .sensor      (sensor),
    .sensor_mask (sensor_mask),
    .delay_zone  (delay_zone),
    .armed       (armed),
    .pending     (pending),
    .siren       (siren),
    .alarm_latch (alarm_latch),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] st,
                       input logic [2:0] lat);
    logic [8:0] act, req;
    logic       e_arm;
    e_arm = (st >= 3'd1) && (st <= 3'd4);
    act = {state, siren, armed, pending, alarm_latch};
    req = {st, st == 3'd3, e_arm, st == 3'd2, lat};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: state=%0d siren=%b armed=%b pending=%b latch=%b ; want state=%0d siren=%b armed=%b pending=%b latch=%b",
               name, state, siren, armed, pending, alarm_latch,
               st, st == 3'd3, e_arm, st == 3'd2, lat);
    end
  endtask

  // Monitor: outputs settle just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, e.st, e.lat);
      end
    end
  end

  task automatic step(input string name, input logic a, input logic d,
                      input logic [2:0] s, input logic [2:0] st,
                      input logic [2:0] lat);
    exp_t e;
    @(negedge clk);
    arm = a;
    disarm = d;
    sensor = s;
    e.name = name;
    e.st = st;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic idle(input string name, input int n,
                      input logic [2:0] st, input logic [2:0] lat);
    for (int i = 0; i < n; i++) step(name, 1'b0, 1'b0, 3'b000, st, lat);
  endtask

  initial begin
    reset = 1'b1;
    #7;
    check("reset_init", 3'd0, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // instant zone trips siren for exactly 6 cycles, then HOLD
    step("t2_arm", 1, 0, 3'b000, 3'd1, 3'b000);
    step("t2_trip", 0, 0, 3'b001, 3'd3, 3'b001);
    step("t2_alarm", 0, 0, 3'b001, 3'd3, 3'b001);
    idle("t2_alarm", 4, 3'd3, 3'b001);
    step("t2_hold", 0, 0, 3'b000, 3'd4, 3'b001);
    step("t2_hold_stay", 0, 0, 3'b000, 3'd4, 3'b001);

    // retrigger from HOLD, then async reset mid-ALARM
    step("t1_retrig", 0, 0, 3'b100, 3'd3, 3'b101);
    step("t1_alarm", 0, 0, 3'b000, 3'd3, 3'b101);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t1_async_reset", 3'd0, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // entry aborted by disarm on the second ENTRY cycle
    step("t3_arm", 1, 0, 3'b000, 3'd1, 3'b000);
    step("t3_dly", 0, 0, 3'b010, 3'd2, 3'b010);
    step("t3_entry2", 0, 0, 3'b000, 3'd2, 3'b010);
    step("t3_disarm", 0, 1, 3'b000, 3'd0, 3'b010);
    step("t3_ignore", 0, 0, 3'b111, 3'd0, 3'b010);

    // full entry delay, siren, HOLD, retrigger by another zone
    step("t4_arm", 1, 0, 3'b000, 3'd1, 3'b000);
    step("t4_dly", 0, 0, 3'b010, 3'd2, 3'b010);
    step("t4_entry", 0, 0, 3'b010, 3'd2, 3'b010);
    idle("t4_entry", 2, 3'd2, 3'b010);
    step("t4_fire", 0, 0, 3'b000, 3'd3, 3'b010);
    idle("t4_alarm", 5, 3'd3, 3'b010);
    step("t4_hold", 0, 0, 3'b000, 3'd4, 3'b010);
    step("t4_retrig", 0, 0, 3'b100, 3'd3, 3'b110);
    idle("t4_alarm2", 5, 3'd3, 3'b110);
    step("t4_hold2", 0, 0, 3'b000, 3'd4, 3'b110);

    // masked zone ignored
    step("t5_disarm", 0, 1, 3'b000, 3'd0, 3'b110);
    sensor_mask = 3'b011;
    step("t5_arm", 1, 0, 3'b000, 3'd1, 3'b000);
    step("t5_masked", 0, 0, 3'b100, 3'd1, 3'b000);
    step("t5_masked2", 0, 0, 3'b100, 3'd1, 3'b000);

    // disarm priority, latch cleared only on arm
    step("t6_both", 1, 1, 3'b000, 3'd0, 3'b000);
    sensor_mask = 3'b111;
    step("t6_arm", 1, 0, 3'b000, 3'd1, 3'b000);
    step("t6_trip", 0, 0, 3'b101, 3'd3, 3'b101);
    step("t6_disarm", 0, 1, 3'b000, 3'd0, 3'b101);
    step("t6_held", 0, 0, 3'b000, 3'd0, 3'b101);
    step("t6_rearm", 1, 0, 3'b000, 3'd1, 3'b000);

    // instant zone cuts an entry countdown short
    step("t7_dly", 0, 0, 3'b010, 3'd2, 3'b010);
    step("t7_inst", 0, 0, 3'b001, 3'd3, 3'b011);
    step("t7_alarm", 0, 0, 3'b000, 3'd3, 3'b011);

    @(negedge clk);
    arm = 1'b0;
    disarm = 1'b0;
    sensor = 3'b000;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending expectations, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
